// File: rtl/ofmap_writer_pkg.sv
// Shared widths, state encoding and the filter-count clamp for the ofmap writer.
package ofmap_writer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int MAX_P  = 24;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FIN   = 2'd2
  } state_t;

  // A requested count above MAX_P is treated as MAX_P.
  function automatic logic [IDX_W-1:0] clamp_p(input logic [IDX_W-1:0] p_in);
    return (p_in > IDX_W'(MAX_P)) ? IDX_W'(MAX_P) : p_in;
  endfunction

endpackage

// File: rtl/ofmap_writer_relu.sv
// Optional ReLU on one 16-bit signed filter result.
module relu16 (
  input  logic        relu_en_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o
);

  // Negative values (bit 15 set) are forced to zero when ReLU is enabled.
  always_comb begin
    data_o = data_i;
    if (relu_en_i && data_i[15]) data_o = '0;
  end

endmodule

// File: rtl/ofmap_writer.sv
// Captures a bank of parallel filter results and writes them one word per
// handshake to output memory, filter 0 first, at base + idx*stride.
//
// Write port handshake: wr_valid/wr_addr/wr_data are registered. A word is
// transferred on a rising edge where wr_valid=1 and wr_ready=1. While
// wr_valid=1 and wr_ready=0 the address and data do not change, and
// wr_valid never drops before its word has been accepted.
module ofmap_writer #(
  parameter int DATA_W = ofmap_writer_pkg::DATA_W,
  parameter int ADDR_W = ofmap_writer_pkg::ADDR_W,
  parameter int MAX_P  = ofmap_writer_pkg::MAX_P
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [4:0]               p,
  input  logic [DATA_W-1:0]        q0,
  input  logic [DATA_W-1:0]        q1,
  input  logic [DATA_W-1:0]        q2,
  input  logic [DATA_W-1:0]        q3,
  input  logic [DATA_W-1:0]        q4,
  input  logic [DATA_W-1:0]        q5,
  input  logic [DATA_W-1:0]        q6,
  input  logic [DATA_W-1:0]        q7,
  input  logic [DATA_W-1:0]        q8,
  input  logic [DATA_W-1:0]        q9,
  input  logic [DATA_W-1:0]        q10,
  input  logic [DATA_W-1:0]        q11,
  input  logic [DATA_W-1:0]        q12,
  input  logic [DATA_W-1:0]        q13,
  input  logic [DATA_W-1:0]        q14,
  input  logic [DATA_W-1:0]        q15,
  input  logic [DATA_W-1:0]        q16,
  input  logic [DATA_W-1:0]        q17,
  input  logic [DATA_W-1:0]        q18,
  input  logic [DATA_W-1:0]        q19,
  input  logic [DATA_W-1:0]        q20,
  input  logic [DATA_W-1:0]        q21,
  input  logic [DATA_W-1:0]        q22,
  input  logic [DATA_W-1:0]        q23,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        addr_stride,
  input  logic                     relu_en,
  input  logic                     wr_ready,
  output logic                     wr_valid,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     load_err,
  output ofmap_writer_pkg::state_t dbg_state_o
);

  import ofmap_writer_pkg::state_t;
  import ofmap_writer_pkg::IDLE;
  import ofmap_writer_pkg::DRAIN;
  import ofmap_writer_pkg::FIN;
  import ofmap_writer_pkg::IDX_W;
  import ofmap_writer_pkg::clamp_p;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    p_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   stride_q;
  logic                relu_q;
  logic [DATA_W-1:0]   cap_q [MAX_P];
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                busy_q;
  logic                done_q;
  logic                load_err_q;

  logic [DATA_W-1:0]   q_in [MAX_P];
  logic [IDX_W-1:0]    p_clamped;
  logic [IDX_W-1:0]    idx_d;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   relu_in;
  logic                relu_en_sel;
  logic [DATA_W-1:0]   relu_out;
  logic [ADDR_W-1:0]   wr_addr_d;

  assign q_in[0]  = q0;
  assign q_in[1]  = q1;
  assign q_in[2]  = q2;
  assign q_in[3]  = q3;
  assign q_in[4]  = q4;
  assign q_in[5]  = q5;
  assign q_in[6]  = q6;
  assign q_in[7]  = q7;
  assign q_in[8]  = q8;
  assign q_in[9]  = q9;
  assign q_in[10] = q10;
  assign q_in[11] = q11;
  assign q_in[12] = q12;
  assign q_in[13] = q13;
  assign q_in[14] = q14;
  assign q_in[15] = q15;
  assign q_in[16] = q16;
  assign q_in[17] = q17;
  assign q_in[18] = q18;
  assign q_in[19] = q19;
  assign q_in[20] = q20;
  assign q_in[21] = q21;
  assign q_in[22] = q22;
  assign q_in[23] = q23;

  // Select the result that becomes the next wr_data: filter 0 from the live
  // inputs on a load, otherwise filter idx+1 from the captured bank.
  // Filter f lives at q[p-1-f] because q0 is the newest shifted value.
  always_comb begin
    p_clamped   = clamp_p(p);
    idx_d       = idx_q + 5'd1;
    rd_idx      = '0;
    relu_in     = '0;
    relu_en_sel = relu_q;
    if (state_q == IDLE) begin
      rd_idx      = p_clamped - 5'd1;
      relu_en_sel = relu_en;
      if (rd_idx < IDX_W'(MAX_P)) relu_in = q_in[rd_idx];
    end else begin
      rd_idx = p_q - idx_q - 5'd2;
      if (rd_idx < IDX_W'(MAX_P)) relu_in = cap_q[rd_idx];
    end
    wr_addr_d = base_q + ({{(ADDR_W-IDX_W){1'b0}}, idx_d} * stride_q);
  end

  relu16 u_relu (
    .relu_en_i (relu_en_sel),
    .data_i    (relu_in),
    .data_o    (relu_out)
  );

  // Control FSM with capture bank and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      p_q        <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      relu_q     <= 1'b0;
      for (int i = 0; i < MAX_P; i++) cap_q[i] <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            for (int i = 0; i < MAX_P; i++) cap_q[i] <= q_in[i];
            p_q      <= p_clamped;
            base_q   <= base_addr;
            stride_q <= addr_stride;
            relu_q   <= relu_en;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            if (p_clamped == '0) begin
              // Nothing to write: go straight to the completion cycle.
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= DRAIN;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= base_addr;
              wr_data_q  <= relu_out;
            end
          end
        end
        DRAIN: begin
          if (load) load_err_q <= 1'b1;
          if (wr_ready) begin
            if (idx_q == p_q - 5'd1) begin
              state_q    <= FIN;
              wr_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_d;
              wr_addr_q <= wr_addr_d;
              wr_data_q <= relu_out;
            end
          end
        end
        FIN: begin
          if (load) load_err_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          wr_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_err    = load_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ofmap_writer.sv
// Bench for ofmap_writer: directed vector table, hand-written multi-cycle
// sequences and randomized transfers checked against a reference model.
module tb_ofmap_writer;

  logic                     clk;
  logic                     rst_n;
  logic                     load;
  logic [4:0]               p;
  logic [15:0]              qv [24];
  logic [15:0]              base_addr;
  logic [15:0]              addr_stride;
  logic                     relu_en;
  logic                     wr_ready;
  logic                     wr_valid;
  logic [15:0]              wr_addr;
  logic [15:0]              wr_data;
  logic                     busy;
  logic                     done;
  logic                     load_err;
  ofmap_writer_pkg::state_t dbg_state;

  ofmap_writer dut (
    .clk(clk), .rst_n(rst_n), .load(load), .p(p),
    .q0(qv[0]),   .q1(qv[1]),   .q2(qv[2]),   .q3(qv[3]),
    .q4(qv[4]),   .q5(qv[5]),   .q6(qv[6]),   .q7(qv[7]),
    .q8(qv[8]),   .q9(qv[9]),   .q10(qv[10]), .q11(qv[11]),
    .q12(qv[12]), .q13(qv[13]), .q14(qv[14]), .q15(qv[15]),
    .q16(qv[16]), .q17(qv[17]), .q18(qv[18]), .q19(qv[19]),
    .q20(qv[20]), .q21(qv[21]), .q22(qv[22]), .q23(qv[23]),
    .base_addr(base_addr), .addr_stride(addr_stride), .relu_en(relu_en),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .load_err(load_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          nwr = 0;
  logic [31:0] first_wr, last_wr;
  int          done_cnt = 0, done_cyc = 0;
  int          err_cnt = 0, err_cyc = 0;
  int          rdy_hold = 0;
  bit          rdy_rand = 0;
  bit          stall_q = 0;
  logic [15:0] stall_addr, stall_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: picks wr_ready for the coming edge, then scores the handshake
  // that edge will perform, checks hold-stability and records pulses.
  always @(negedge clk) begin
    logic nr;
    logic [31:0] e;
    if (!rst_n) begin
      stall_q  = 1'b0;
      wr_ready = 1'b1;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (load_err) begin err_cnt++; err_cyc = cyc; end
      if (stall_q) begin
        chk("stall_valid", {31'd0, wr_valid}, 32'd1);
        chk("stall_word", {wr_addr, wr_data}, {stall_addr, stall_data});
      end
      nr = 1'b1;
      if (wr_valid && rdy_hold > 0) begin
        nr = 1'b0;
        rdy_hold--;
      end else if (rdy_rand) begin
        nr = ($urandom_range(0, 3) != 0);
      end
      wr_ready = nr;
      if (wr_valid && nr) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", {wr_addr, wr_data}, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write", {wr_addr, wr_data}, e);
        end
        if (nwr == 0) first_wr = {wr_addr, wr_data};
        last_wr = {wr_addr, wr_data};
        nwr++;
      end
      stall_q    = wr_valid && !nr;
      stall_addr = wr_addr;
      stall_data = wr_data;
    end
  end

  // ---------------- reference model ----------------
  // Expected write list: filter f goes to base+f*stride, carrying q[pc-1-f]
  // with optional ReLU, pc being the count limited to 24.
  task automatic build_exp(input int pl, input logic [15:0] b, input logic [15:0] s, input bit rl);
    int pc;
    logic [15:0] d;
    pc = (pl > 24) ? 24 : pl;
    for (int f = 0; f < pc; f++) begin
      d = qv[pc - 1 - f];
      if (rl && $signed(d) < 0) d = 16'h0000;
      exp_q.push_back({16'(int'(b) + f * int'(s)), d});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the load.
  task automatic start_load(input int pl, input logic [15:0] b, input logic [15:0] s,
                            input bit rl, output int t);
    p           = 5'(pl);
    base_addr   = b;
    addr_stride = s;
    relu_en     = rl;
    load        = 1'b1;
    build_exp(pl, b, s, rl);
    nwr = 0;
    t = cyc;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int t, input int dt, input bit chk_dt);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles (cycle %0d)", cyc);
      exp_q.delete();
    end else begin
      if (chk_dt) chk("done_time", 32'(done_cyc - t), 32'(dt));
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("exp_empty", 32'(exp_q.size()), 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic fill_q(input logic [3:0][15:0] lo);
    for (int i = 0; i < 24; i++) qv[i] = (i < 4) ? lo[i] : 16'(16'h1000 + i);
  endtask

  typedef struct {
    int               p;
    logic [15:0]      base;
    logic [15:0]      stride;
    bit               relu;
    int               hold;
    int               nw;
    logic [31:0]      first_wr;
    logic [31:0]      last_wr;
    int               dt;
    logic [3:0][15:0] qlo;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    int d0, t;
    fill_q(v.qlo);
    rdy_hold = v.hold;
    d0 = done_cnt;
    start_load(v.p, v.base, v.stride, v.relu, t);
    wait_done(d0, t, v.dt, 1'b1);
    chk("n_writes", 32'(nwr), 32'(v.nw));
    if (v.nw > 0) begin
      chk("first_write", first_wr, v.first_wr);
      chk("last_write", last_wr, v.last_wr);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0, e0, t, pl;
    logic [15:0] b, s;
    bit rl;

    rst_n = 1'b0; load = 1'b0; p = '0; base_addr = '0; addr_stride = '0;
    relu_en = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 24; i++) qv[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, load_err, 1'b0}, 32'd0);
    chk("rst_word", {wr_addr, wr_data}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs[0] = '{p:3,  base:16'h0100, stride:16'h0004, relu:0, hold:0, nw:3,
                first_wr:32'h0100_0011, last_wr:32'h0108_0033, dt:4,
                qlo:{16'h0000, 16'h0011, 16'h0022, 16'h0033}};
    vecs[1] = '{p:2,  base:16'h0200, stride:16'h0002, relu:1, hold:3, nw:2,
                first_wr:32'h0200_0000, last_wr:32'h0202_7FFF, dt:6,
                qlo:{16'h0000, 16'h0000, 16'h8005, 16'h7FFF}};
    vecs[2] = '{p:0,  base:16'h0300, stride:16'h0001, relu:0, hold:0, nw:0,
                first_wr:32'h0, last_wr:32'h0, dt:1,
                qlo:{16'h1003, 16'h1002, 16'h1001, 16'h1000}};
    vecs[3] = '{p:31, base:16'h0000, stride:16'h0001, relu:0, hold:0, nw:24,
                first_wr:32'h0000_1017, last_wr:32'h0017_1000, dt:25,
                qlo:{16'h1003, 16'h1002, 16'h1001, 16'h1000}};
    vecs[4] = '{p:2,  base:16'hFFFC, stride:16'h0004, relu:0, hold:0, nw:2,
                first_wr:32'hFFFC_1001, last_wr:32'h0000_1000, dt:3,
                qlo:{16'h1003, 16'h1002, 16'h1001, 16'h1000}};
    vecs[5] = '{p:4,  base:16'h0010, stride:16'h0010, relu:0, hold:0, nw:4,
                first_wr:32'h0010_7FFF, last_wr:32'h0040_8000, dt:5,
                qlo:{16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000}};
    vecs[6] = '{p:24, base:16'h1000, stride:16'hFFFF, relu:1, hold:0, nw:24,
                first_wr:32'h1000_1017, last_wr:32'h0FE9_1000, dt:25,
                qlo:{16'h1003, 16'h1002, 16'h1001, 16'h1000}};

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Load while draining: rejected, flagged once, original writes intact.
    fill_q({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    d0 = done_cnt; e0 = err_cnt;
    start_load(5, 16'h0400, 16'h0002, 1'b0, t);
    @(posedge clk); #1;
    p = 5'd7; base_addr = 16'h9999; qv[0] = 16'hDEAD; qv[4] = 16'hBEEF; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    wait_done(d0, t, 6, 1'b1);
    chk("drain_err_count", 32'(err_cnt - e0), 32'd1);
    chk("drain_err_cycle", 32'(err_cyc - t), 32'd3);
    chk("drain_nwr", 32'(nwr), 32'd5);

    // Load on the final handshake cycle and again in FIN: both rejected.
    fill_q({16'h0044, 16'h0033, 16'h0022, 16'h0011});
    d0 = done_cnt; e0 = err_cnt;
    start_load(2, 16'h0500, 16'h0001, 1'b0, t);
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fin_err_count", 32'(err_cnt - e0), 32'd2);
    chk("fin_err_cycle", 32'(err_cyc - t), 32'd4);
    chk("fin_done_cycle", 32'(done_cyc - t), 32'd3);
    chk("fin_done_count", 32'(done_cnt - d0), 32'd1);
    chk("fin_nwr", 32'(nwr), 32'd2);
    chk("fin_idle", {30'd0, busy, wr_valid}, 32'd0);

    // Reset after the first of five writes aborts without done.
    fill_q({16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01});
    d0 = done_cnt;
    start_load(5, 16'h0600, 16'h0001, 1'b0, t);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_valid_busy", {30'd0, wr_valid, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_word", {wr_addr, wr_data}, 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_nwr", 32'(nwr), 32'd1);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_write", 32'(nwr), 32'd1);
    run_vec(vecs[5]);

    // Randomized transfers under random backpressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      pl = $urandom_range(0, 31);
      b  = 16'($urandom);
      s  = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 8));
      rl = 1'($urandom_range(0, 1));
      for (int i = 0; i < 24; i++) qv[i] = 16'($urandom);
      d0 = done_cnt;
      start_load(pl, b, s, rl, t);
      wait_done(d0, t, 0, 1'b0);
      chk("rand_nwr", 32'(nwr), 32'((pl > 24) ? 24 : pl));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ofmap_writer.md
OFMAP_WRITER -- requirements
Module: ofmap_writer

Interface
REQ-001 Parameter: DATA_W, 16, width of each filter result and of wr_data.
REQ-002 Parameter: ADDR_W, 16, width of base_addr, addr_stride and wr_addr.
REQ-003 Parameter: MAX_P, 24, maximum number of filter results per load.
REQ-004 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-005 Ports:
- clk, input, 1: rising-edge clock for all state.
- rst_n, input, 1: synchronous active-low reset.
- load, input, 1: one-cycle pulse that captures q0..q23, p, base_addr, addr_stride and relu_en.
- p, input, 5: number of valid filter results.
- q0..q23, input, 16 each: parallel filter results from the upstream shift register; q0 holds the most recently shifted value.
- base_addr, input, ADDR_W: output-memory address of filter 0.
- addr_stride, input, ADDR_W: address increment between consecutive filters.
- relu_en, input, 1: enables ReLU on results.
- wr_ready, input, 1: memory accepts the current word.
- wr_valid, output, 1: wr_addr and wr_data are valid.
- wr_addr, output, ADDR_W: write address.
- wr_data, output, DATA_W: write data.
- busy, output, 1: high whenever the FSM is not in IDLE.
- done, output, 1: one-cycle pulse after the last write handshake.
- load_err, output, 1: one-cycle pulse when a load is rejected.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, DRAIN and FIN.
REQ-007 When load=1 in IDLE, the block SHALL capture all inputs into internal registers, set the index to 0, and move to DRAIN on the next edge.
- If the captured p=0, the block SHALL instead go to FIN.
REQ-008 A captured p greater than 24 SHALL be clamped to 24.
REQ-009 In DRAIN, wr_valid SHALL be 1, with the following content:
- wr_data = result(idx).
- wr_addr = base_addr + idx*addr_stride, computed modulo 2^ADDR_W.
REQ-010 The filter mapping SHALL be result(f) = captured q[p-1-f], so that filter 0 is the first value the upstream stage shifted in.
REQ-011 When relu_en=1, a result whose bit 15 is set (signed negative) SHALL be output as 0; otherwise the result SHALL pass unchanged.
REQ-012 A handshake occurs when wr_valid=1 and wr_ready=1; on each handshake idx SHALL increment and wr_addr SHALL advance by addr_stride.
- wr_addr and wr_data SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-013 The handshake with idx=p-1 SHALL move the FSM to FIN.
REQ-014 FIN SHALL last one cycle, with done=1 and wr_valid=0, and SHALL then return to IDLE.
REQ-015 Timing with wr_ready held at 1:
- load at cycle t gives wr_valid=1 from t+1 to t+p.
- done=1 at t+p+1.
- IDLE again at t+p+2.
REQ-016 A load received while busy=1 SHALL be ignored, and load_err=1 SHALL be asserted on the next cycle; captured data SHALL be unaffected.
- This applies when load arrives in the same cycle as the final handshake.
- A load arriving in the FIN cycle is also rejected.
REQ-017 Captured registers SHALL change only on an accepted load.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set the following to 0:
- wr_valid, done, load_err, busy;
- wr_addr, wr_data, idx;
- all captured registers.
REQ-019 A reset during DRAIN SHALL abort the transfer with no done pulse; the next write after release SHALL require a new load.

Structure
REQ-020 A shared package SHALL hold DATA_W, ADDR_W, MAX_P and the state encoding (IDLE=2'd0, DRAIN=2'd1, FIN=2'd2).
REQ-021 ReLU SHALL be a single combinational sub-module named relu16; the FSM, capture registers and address generation SHALL stay in ofmap_writer.

Verification
REQ-022 Basic drain: p=3, q2=0x0011, q1=0x0022, q0=0x0033, base=0x0100, stride=4, relu_en=0, wr_ready=1.
- Required writes: (0x0100, 0x0011), (0x0104, 0x0022), (0x0108, 0x0033).
- done SHALL pulse at t+4.
REQ-023 Backpressure and ReLU: p=2, q1=0x8005, q0=0x7FFF, relu_en=1, wr_ready low for 3 cycles at the first word.
- The first word SHALL be held stable with data 0x0000; the second word SHALL be 0x7FFF.
REQ-024 Boundaries:
- p=0: no wr_valid, and done at t+1.
- p=31: exactly 24 writes, the last carrying q0.
- base=0xFFFC, stride=4: the second address SHALL wrap to 0x0000.
REQ-025 A load during DRAIN SHALL produce load_err=1 for one cycle, and the write sequence SHALL be unchanged.
REQ-026 Reset mid-drain: rst_n=0 after 1 of 5 writes SHALL give wr_valid=0 and busy=0 next cycle, no done pulse, and a clean drain after a new load.
